maze_probe: RTL
===============

# maze_probe

Collision probe that reads the maze bitmap through its pixel-index/colour interface. Given a candidate square-sprite position, it walks every pixel of the sprite footprint and reports whether the move is blocked by a wall or reaches the goal colour. It sits between the player-movement logic, which issues one request per attempted step, and the maze colour ROM. That ROM returns `data` registered one clock after `index`.

## Interface
Parameters:
- `WIDTH`, 96: screen width in pixels; index = y*WIDTH + x.
- `HEIGHT`, 64: screen height in pixels.
- `SPRITE`, 3: side length of the square sprite footprint; N = SPRITE*SPRITE pixels.
- `WALL_COLOR`, 16'hFFFF: pixel value treated as wall.
- `GOAL_COLOR`, 16'h001F: pixel value treated as goal.

Ports:
- `clk` input 1: single clock; all state on posedge.
- `reset` input 1: asynchronous, active-high reset.
- `req` input 1: start probe; sampled only while idle.
- `x` input 7: candidate sprite top-left column.
- `y` input 6: candidate sprite top-left row.
- `index` output 13: pixel address to the maze ROM; registered.
- `data` input 16: ROM colour; valid one clock after `index`.
- `busy` output 1: scan in progress.
- `done` output 1: one-cycle pulse; `blocked` and `goal` are valid while it is high.
- `blocked` output 1: footprint touches a wall or lies off-screen; held until the next `done`.
- `goal` output 1: footprint touches the goal colour and is not blocked; held until the next `done`.

## Operation
- FSM states: IDLE, SCAN, DRAIN.
- IDLE with `req`=1:
  - Latch `x` and `y`. Evaluate bounds using 8-bit sums: off-screen if x+SPRITE > WIDTH or y+SPRITE > HEIGHT.
  - Off-screen: pulse `done` with `blocked`=1 and `goal`=0. Stay in IDLE. No ROM access.
  - In bounds: `index` <= y*WIDTH + x; clear the hit flags; `busy`=1; go to SCAN.
- SCAN:
  - Row-major walk over column offset c and row offset r, each 0..SPRITE-1.
  - One new `index` per cycle.
  - Index is computed incrementally: +1 within a row; +(WIDTH-SPRITE+1) at the end of a row. No multiplier beyond the start address.
  - After issuing pixel N-1, go to DRAIN.
- Compare pipeline:
  - A 2-stage valid shift register tracks in-flight addresses.
  - When stage 2 is valid: `data`==WALL_COLOR sets wall_hit; `data`==GOAL_COLOR sets goal_hit.
- DRAIN:
  - Waits for the last compare.
  - Then pulse `done`, with `blocked`=wall_hit and `goal`=goal_hit & ~wall_hit.
  - Drop `busy` and return to IDLE.
- `req` while `busy` is ignored and not queued.
- `x` and `y` changing after acceptance have no effect.
- Reset values: `index`=0, `busy`=0, `done`=0, `blocked`=0, `goal`=0, state IDLE.
- Reset mid-scan aborts the scan immediately; no `done` is produced.

## Timing
Edges are numbered from edge 0, the edge at which `req` is accepted.
- Address k (k=0..N-1) is registered at edge k.
- The ROM registers its data at edge k+1.
- The probe samples that data at edge k+2.
- Full scan: `done` is registered at edge N+1 and is high for one cycle. For N=9 this is edge 10.
- `busy` is high from after edge 0 until `done` rises.
- Off-screen: `done` is registered at edge 0, giving 1-cycle latency.
- Back-to-back: a new `req` is accepted on the edge after `done` falls. The minimum request period is N+2 cycles.

## Configuration
- `MAZE_PROBE_EARLY_EXIT_EN` defined:
  - The first wall match at compare edge k+2 pulses `done` with `blocked`=1 on that edge.
  - Remaining issues and in-flight compares are discarded; `goal`=0.
  - The FSM returns to IDLE.
- Undefined: every probe scans all N pixels, giving fixed latency N+1 for in-bounds requests.

## Test plan
The bench uses a 1-cycle-latency model of the current maze: rows 0-2 wall except columns 83-92; columns 0-2 and 93-95 wall; rows 3-12 open; goal colour 16'h001F at rows 52-60, columns 84-92.
- req at (3,3) -> `done` at edge 10; `blocked`=0, `goal`=0; `index` sequence 291,292,293,387,388,389,483,484,485.
- req at (85,53) -> `done` at edge 10; `blocked`=0, `goal`=1.
- req at (94,0) -> off-screen; `done` at edge 0, `blocked`=1, `index` unchanged.
- req at (0,3), first pixel is wall -> with `MAZE_PROBE_EARLY_EXIT_EN`: `done` at edge 2, `blocked`=1. Without: `done` at edge 10, `blocked`=1.
- req at (10,11), wall only at the last pixel (12,13) -> `done` at edge 10, `blocked`=1 in both configurations.
- req at (3,3), then `reset` pulsed at edge 4 -> all outputs return to 0; no `done` pulse; a new req at (3,3) completes normally.

Source files
------------

// File: rtl/maze_probe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : maze_probe
// Brief   : Walks a SPRITE x SPRITE footprint through a 1-cycle-latency maze
//           colour ROM and reports wall / goal contact for a candidate move.
//           Optional macro MAZE_PROBE_EARLY_EXIT_EN ends a scan on the first wall.
// Rev     : 1.0  initial release
// ============================================================================
module maze_probe #(
    parameter int          WIDTH      = 96,
    parameter int          HEIGHT     = 64,
    parameter int          SPRITE     = 3,
    parameter logic [15:0] WALL_COLOR = 16'hFFFF,
    parameter logic [15:0] GOAL_COLOR = 16'h001F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [6:0]  x,
    input  logic [5:0]  y,
    output logic [12:0] index,
    input  logic [15:0] data,
    output logic        busy,
    output logic        done,
    output logic        blocked,
    output logic        goal
);

    localparam int c_N  = SPRITE * SPRITE;
    localparam int c_KW = (c_N > 2) ? $clog2(c_N) : 1;
    localparam int c_CW = (SPRITE > 2) ? $clog2(SPRITE) : 1;

    localparam logic [c_KW-1:0] c_K_PRELAST = c_KW'((c_N >= 2) ? (c_N - 2) : 0);
    localparam logic [c_CW-1:0] c_COL_LAST  = c_CW'(SPRITE - 1);
    localparam logic [12:0]     c_ROW_STEP  = 13'(WIDTH - SPRITE + 1);
    localparam logic [12:0]     c_WIDTH13   = 13'(WIDTH);
    localparam logic [7:0]      c_SPRITE8   = 8'(SPRITE);
    localparam logic [7:0]      c_WIDTH8    = 8'(WIDTH);
    localparam logic [7:0]      c_HEIGHT8   = 8'(HEIGHT);

`ifdef MAZE_PROBE_EARLY_EXIT_EN
    localparam bit c_EARLY_EXIT = 1'b1;
`else
    localparam bit c_EARLY_EXIT = 1'b0;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [12:0]     index_q, index_d;
    logic [c_KW-1:0] cnt_q, cnt_d;
    logic [c_CW-1:0] col_q, col_d;
    logic            v1_q, v1_d;
    logic            v2_q, v2_d;
    logic            wall_hit_q, wall_hit_d;
    logic            goal_hit_q, goal_hit_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            blocked_q, blocked_d;
    logic            goal_q, goal_d;

    logic [7:0]  w_x_end;
    logic [7:0]  w_y_end;
    logic        w_offscreen;
    logic [12:0] w_start_addr;
    logic        w_wall_px;
    logic        w_goal_px;
    logic        w_scan_last;
    logic        w_final;
    logic        w_abort;
    logic        w_wall_any;

    assign w_x_end      = {1'b0, x} + c_SPRITE8;
    assign w_y_end      = {2'b00, y} + c_SPRITE8;
    assign w_offscreen  = (w_x_end > c_WIDTH8) || (w_y_end > c_HEIGHT8);
    assign w_start_addr = ({7'd0, y} * c_WIDTH13) + {6'd0, x};

    // Stage 2 valid lines up with the ROM word for the address issued two edges ago.
    assign w_wall_px   = v2_q && (data == WALL_COLOR);
    assign w_goal_px   = v2_q && (data == GOAL_COLOR);
    assign w_wall_any  = wall_hit_q | w_wall_px;
    assign w_scan_last = (state_q == S_SCAN) && (cnt_q == c_K_PRELAST);
    assign w_final     = (state_q == S_DRAIN) && v2_q && !v1_q;
    assign w_abort     = c_EARLY_EXIT && w_wall_px && (state_q != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req && !w_offscreen) begin
                    state_d = (c_N == 1) ? S_DRAIN : S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_abort) begin
                    state_d = S_IDLE;
                end else if (w_scan_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_abort || w_final) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        index_d    = index_q;
        cnt_d      = cnt_q;
        col_d      = col_q;
        v1_d       = 1'b0;
        v2_d       = v1_q;
        wall_hit_d = wall_hit_q | w_wall_px;
        goal_hit_d = goal_hit_q | w_goal_px;
        busy_d     = busy_q;
        done_d     = 1'b0;
        blocked_d  = blocked_q;
        goal_d     = goal_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (w_offscreen) begin
                        done_d    = 1'b1;
                        blocked_d = 1'b1;
                        goal_d    = 1'b0;
                    end else begin
                        index_d    = w_start_addr;
                        cnt_d      = '0;
                        col_d      = '0;
                        v1_d       = 1'b1;
                        wall_hit_d = 1'b0;
                        goal_hit_d = 1'b0;
                        busy_d     = 1'b1;
                    end
                end
            end
            S_SCAN: begin
                // Row-major walk: step by one, or jump to the next row's first column.
                v1_d  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (col_q == c_COL_LAST) begin
                    col_d   = '0;
                    index_d = index_q + c_ROW_STEP;
                end else begin
                    col_d   = col_q + 1'b1;
                    index_d = index_q + 13'd1;
                end
            end
            default: ;
        endcase

        if (w_abort) begin
            done_d    = 1'b1;
            blocked_d = 1'b1;
            goal_d    = 1'b0;
            busy_d    = 1'b0;
            v1_d      = 1'b0;
            v2_d      = 1'b0;
        end else if (w_final) begin
            done_d    = 1'b1;
            blocked_d = w_wall_any;
            goal_d    = (goal_hit_q | w_goal_px) & ~w_wall_any;
            busy_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index_q    <= '0;
            cnt_q      <= '0;
            col_q      <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            wall_hit_q <= 1'b0;
            goal_hit_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            blocked_q  <= 1'b0;
            goal_q     <= 1'b0;
        end else begin
            index_q    <= index_d;
            cnt_q      <= cnt_d;
            col_q      <= col_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            wall_hit_q <= wall_hit_d;
            goal_hit_q <= goal_hit_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            blocked_q  <= blocked_d;
            goal_q     <= goal_d;
        end
    end

    assign index   = index_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign blocked = blocked_q;
    assign goal    = goal_q;

endmodule
`default_nettype wire
